// File: rtl/distance_text_pkg.sv
// Shared types and constants for the distance text line sequencer.
package distance_text_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT_VB,
    ST_WRITE
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_D     = 8'h44;
  localparam logic [7:0] ASCII_I     = 8'h49;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_M     = 8'h4D;

  localparam int unsigned DIGIT_COL0 = 6;
  localparam int unsigned LINE_LEN   = 16;
  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one input bit per cycle, DIST_W cycles after start.
module bin2bcd_seq
  import distance_text_pkg::*;
#(
  parameter int unsigned DIST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIST_W-1:0] din,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  localparam int unsigned CNT_W = $clog2(DIST_W + 1);

  logic [DIST_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;
  logic [BCD_W-1:0]  adj;

  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    adj   = bcd_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    done = run_q && (cnt_q == CNT_W'(DIST_W - 1));

    if (start) begin
      sh_d  = din;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {adj[BCD_W-2:0], sh_q[DIST_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/distance_text_ctrl.sv
// Converts a distance sample to "DIST: nnnnn CM  " and writes it to the char buffer during vblank.
module distance_text_ctrl
  import distance_text_pkg::*;
#(
  parameter int unsigned DIST_W = 16,
  parameter int unsigned MAX_CM = 400,
  parameter int unsigned ROW    = 0
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  output logic              dist_ready,
  input  logic              vblnk_in,
  output logic              wr_en,
  output logic [6:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam logic [1:0] ROW_B = 2'(ROW);

  state_e             state_q, state_d;
  logic [3:0]         col_q, col_d;
  logic               over_q, over_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               wr_en_q, wr_en_d;
  logic [6:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               accept, emit, conv_done;
  logic [BCD_W-1:0]   bcd;

  function automatic logic [7:0] line_char(input logic [3:0] col,
                                           input logic [BCD_W-1:0] val,
                                           input logic ovr);
    int unsigned      di;
    logic [BCD_W-1:0] upper;
    logic [3:0]       dig;
    line_char = ASCII_SPACE;
    di        = 32'(col) - DIGIT_COL0;
    case (col)
      4'd0:  line_char = ASCII_D;
      4'd1:  line_char = ASCII_I;
      4'd2:  line_char = ASCII_S;
      4'd3:  line_char = ASCII_T;
      4'd4:  line_char = ASCII_COLON;
      4'd12: line_char = ASCII_C;
      4'd13: line_char = ASCII_M;
      default: begin
        if (col >= 4'(DIGIT_COL0) && col < 4'(DIGIT_COL0 + NUM_DIGITS)) begin
          dig   = val[4*(NUM_DIGITS-1-di) +: 4];
          // this digit and all more-significant ones zero => leading zero (last digit always shown)
          upper = val >> (4*(NUM_DIGITS-1-di));
          if (ovr)                                   line_char = ASCII_DASH;
          else if (upper == '0 && di < NUM_DIGITS-1) line_char = ASCII_SPACE;
          else                                       line_char = ASCII_0 + {4'b0, dig};
        end
      end
    endcase
  endfunction

  assign accept = dist_valid && ready_q && (state_q == ST_IDLE);

  bin2bcd_seq #(.DIST_W(DIST_W)) u_bin2bcd (
    .clk   (pclk),
    .rst_n (rst_n),
    .start (accept),
    .din   (dist_in),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    over_d    = over_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    emit      = 1'b0;

    case (state_q)
      ST_IDLE: if (accept) begin
        over_d  = 32'(dist_in) > MAX_CM;
        col_d   = '0;
        state_d = ST_CONV;
      end
      ST_CONV:    if (conv_done) state_d = ST_WAIT_VB;
      ST_WAIT_VB: if (vblnk_in) begin
        emit    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: if (vblnk_in) begin
        emit = 1'b1;
        if (col_q == 4'(LINE_LEN - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // col_q is the next column to emit; the write leaving WAIT_VB is column 0
    if (emit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = {1'b0, ROW_B, col_q};
      wr_data_d = line_char(col_q, bcd, over_q);
      col_d     = col_q + 1'b1;
    end

    // busy spans one extra cycle after leaving WRITE so it covers the last registered write
    busy_d  = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    ready_d = !busy_d;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      over_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= ASCII_SPACE;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      over_q    <= over_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign dist_ready = ready_q;
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_distance_text_ctrl.sv
// Randomized self-checking bench: expected text lines are built with string formatting.
module tb_distance_text_ctrl;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [15:0] dist_in;
  logic        dist_valid;
  logic        vblnk_in;
  logic        dist_ready, wr_en, busy;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        dist_ready2, wr_en2, busy2;
  logic [6:0]  wr_addr2;
  logic [7:0]  wr_data2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

  distance_text_ctrl #(.DIST_W(16), .MAX_CM(400), .ROW(0)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .dist_in(dist_in), .dist_valid(dist_valid),
    .dist_ready(dist_ready), .vblnk_in(vblnk_in), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  distance_text_ctrl #(.DIST_W(16), .MAX_CM(400), .ROW(2)) u_dut_row2 (
    .pclk(pclk), .rst_n(rst_n), .dist_in(dist_in), .dist_valid(dist_valid),
    .dist_ready(dist_ready2), .vblnk_in(vblnk_in), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .busy(busy2)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic string expected_line(input int v);
    string digits;
    if (v > 400) digits = "-----";
    else         digits = $sformatf("%5d", v);
    return {"DIST: ", digits, " CM  "};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!dist_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check_val("ready_before_start", dist_ready, 1);
  endtask

  // One complete transaction; cycle 1 is the cycle after the accepting edge.
  task automatic run_sample(input int v, input bit pause, input bit noise);
    string line;
    int cyc, nwr, first, rdy, gaps, busy_drop, pause_cnt;
    bit finished;
    line = expected_line(v);
    wait_ready();
    @(negedge pclk);
    dist_in    = 16'(v);
    dist_valid = 1'b1;
    @(negedge pclk);
    dist_valid = 1'b0;
    cyc = 1; nwr = 0; first = -1; rdy = -1; gaps = 0; busy_drop = 0; pause_cnt = 0;
    finished = 1'b0;
    check_val("busy_cycle1", busy, 1);
    check_val("ready_cycle1", dist_ready, 0);
    while (!finished && cyc < 300) begin
      if (pause_cnt > 0) begin
        pause_cnt--;
        if (pause_cnt == 0) vblnk_in = 1'b1;
      end
      if (wr_en) begin
        if (nwr < 16) begin
          check_val($sformatf("addr_r0_%0d", nwr), wr_addr, nwr);
          check_val($sformatf("data_r0_%0d", nwr), wr_data, line[nwr]);
        end
        nwr++;
        if (first < 0) first = cyc;
        if (pause && nwr == 3) begin
          vblnk_in  = 1'b0;
          pause_cnt = 50;
        end
      end else if (nwr > 0 && nwr < 16) begin
        gaps++;
      end
      if (wr_en2 && nwr <= 16 && nwr > 0) begin
        check_val($sformatf("addr_r2_%0d", nwr-1), wr_addr2, 32 + nwr - 1);
        check_val($sformatf("data_r2_%0d", nwr-1), wr_data2, line[nwr-1]);
      end
      check_val("wr_en_rows_agree", wr_en2, wr_en);
      if (dist_ready) begin
        finished = 1'b1;
        rdy      = cyc;
        check_val("busy_low_at_ready", busy, 0);
      end else if (!busy) begin
        busy_drop++;
      end
      if (noise && (cyc == 5 || cyc == 25)) begin
        dist_in    = 16'd99;
        dist_valid = 1'b1;
      end else begin
        dist_valid = 1'b0;
      end
      if (!finished) begin
        @(negedge pclk);
        cyc++;
      end
    end
    dist_valid = 1'b0;
    vblnk_in   = 1'b1;
    check_val("finished_in_budget", finished, 1);
    check_val("num_writes", nwr, 16);
    check_val("first_wr_cycle", first, 18);
    check_val("pause_cycles", gaps, pause ? 50 : 0);
    check_val("ready_cycle", rdy, pause ? 84 : 34);
    check_val("busy_drops", busy_drop, 0);
  endtask

  initial begin
    int nw;
    rst_n      = 1'b0;
    dist_in    = '0;
    dist_valid = 1'b0;
    vblnk_in   = 1'b1;
    repeat (3) @(negedge pclk);
    check_val("rst_ready", dist_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    check_val("rst_wr_data", wr_data, 8'h20);
    rst_n = 1'b1;
    @(negedge pclk);

    run_sample(123, 1'b0, 1'b0);
    run_sample(0, 1'b0, 1'b0);
    run_sample(400, 1'b0, 1'b0);
    run_sample(401, 1'b0, 1'b0);
    run_sample(65535, 1'b0, 1'b0);
    run_sample(7, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) run_sample(int'($urandom_range(0, 1200)), 1'b0, 1'b0);
    run_sample(int'($urandom_range(0, 65535)), 1'b0, 1'b0);
    run_sample(int'($urandom_range(0, 400)), 1'b1, 1'b0);
    run_sample(321, 1'b0, 1'b1);
    run_sample(99, 1'b0, 1'b0);

    // Reset in the middle of conversion
    wait_ready();
    @(negedge pclk);
    dist_in    = 16'd250;
    dist_valid = 1'b1;
    @(negedge pclk);
    dist_valid = 1'b0;
    repeat (7) @(negedge pclk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_ready", dist_ready, 1);
    check_val("midrst_wr_en", wr_en, 0);
    check_val("midrst_busy", busy, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (wr_en || wr_en2) nw++;
    end
    check_val("midrst_no_writes", nw, 0);
    run_sample(int'($urandom_range(0, 999)), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
